// File: rtl/alu_issue_ctrl.sv
// Issue front-end for the 16-bit ALU: registers a request onto the ALU inputs,
// waits the op-dependent settle time and returns the captured result.
//
// state | meaning
// IDLE  | ready for a request; alu_* hold the last issued operands
// EXEC  | operands on the ALU, counting down the settle time
// RESP  | response presented, held until the consumer takes it
module alu_issue_ctrl #(
    parameter int COMB_WAIT  = 1,
    parameter int SHIFT_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy
);

    localparam int MAX_WAIT = (COMB_WAIT > SHIFT_WAIT) ? COMB_WAIT : SHIFT_WAIT;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    logic req_illegal;
    logic req_div_zero;
    logic req_shift;

    assign req_illegal  = req_op[3] & (req_op[2] | req_op[1]);
    assign req_div_zero = (req_op == 4'b1001) && (req_b == 16'h0000);
    assign req_shift    = (req_op[3:1] == 3'b011);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        rsp_op    <= req_op;
                        // Trapped ops bypass the ALU and respond straight away
                        if (req_illegal) begin
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (req_div_zero) begin
                            rsp_data  <= {req_a, 16'hFFFF};
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a    <= req_a;
                            alu_b    <= req_b;
                            alu_op   <= req_op;
                            wait_cnt <= req_shift ? CW'(SHIFT_WAIT) : CW'(COMB_WAIT);
                            state    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == CW'(1)) begin
                        rsp_data  <= alu_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
